// File: rtl/snake_dir_ctrl.sv
// Direction controller between the IR key decoder and the snake game core.
// Queues legal turns from NEC key codes and applies one turn per game step.
module snake_dir_ctrl #(
    parameter logic [31:0] UP    = 32'h20DF6A95,
    parameter logic [31:0] DOWN  = 32'h20DFEA15,
    parameter logic [31:0] LEFT  = 32'h20DF1AE5,
    parameter logic [31:0] RIGHT = 32'h20DF9A65,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       game_clk,
    input  logic                       reset_n,
    input  logic [31:0]                ir_code,
    input  logic                       ir_valid,
    input  logic                       step,
    input  logic                       halt,
    output logic [31:0]                direction,
    output logic [1:0]                 dir_idx,
    output logic                       dir_changed,
    output logic                       reject,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [31:0]       direction_q, direction_d;
    logic [1:0]        dir_idx_q, dir_idx_d;
    logic              changed_q, changed_d;
    logic              reject_q, reject_d;
    logic              overflow_q, overflow_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]        queue_q [DEPTH];

    logic              code_hit;
    logic [1:0]        code_idx;
    logic              cmd_valid;
    logic [PtrW-1:0]   tail_ptr;
    logic [1:0]        ref_idx;
    logic              has_ref;
    logic              legal;
    logic              q_empty;
    logic              q_full;
    logic              pop;
    logic              push;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    function automatic logic [31:0] idx_to_code(input logic [1:0] idx);
        logic [31:0] code;
        unique case (idx)
            2'd0: code = UP;
            2'd1: code = DOWN;
            2'd2: code = LEFT;
            2'd3: code = RIGHT;
        endcase
        return code;
    endfunction

    // Priority chain rather than a parallel case: parameters may be overridden to equal values.
    always_comb begin
        code_hit = 1'b1;
        code_idx = 2'd0;
        if (ir_code == UP) begin
            code_idx = 2'd0;
        end else if (ir_code == DOWN) begin
            code_idx = 2'd1;
        end else if (ir_code == LEFT) begin
            code_idx = 2'd2;
        end else if (ir_code == RIGHT) begin
            code_idx = 2'd3;
        end else begin
            code_hit = 1'b0;
        end
    end

    assign cmd_valid = ir_valid && code_hit;
    assign q_empty   = (count_q == '0);
    assign q_full    = (count_q == FullCnt);
    assign tail_ptr  = (wr_ptr_q == '0) ? LastPtr : wr_ptr_q - PtrW'(1);

    // Reference is the last queued turn, else the live heading; none while stationary.
    assign has_ref = !q_empty || (state_q == StRun);
    assign ref_idx = q_empty ? dir_idx_q : queue_q[tail_ptr];

    // Opposites differ only in bit 0, so equal bit 1 means same-or-opposite.
    assign legal = !has_ref || (code_idx[1] != ref_idx[1]);

    assign pop  = !halt && step && !q_empty;
    assign push = !halt && cmd_valid && legal && (!q_full || pop);

    always_comb begin
        state_d     = state_q;
        direction_d = direction_q;
        dir_idx_d   = dir_idx_q;
        changed_d   = 1'b0;
        reject_d    = 1'b0;
        overflow_d  = 1'b0;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;

        if (halt) begin
            state_d     = StIdle;
            direction_d = '0;
            dir_idx_d   = 2'd0;
            changed_d   = (state_q == StRun);
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
        end else begin
            if (pop) begin
                state_d     = StRun;
                dir_idx_d   = queue_q[rd_ptr_q];
                direction_d = idx_to_code(queue_q[rd_ptr_q]);
                changed_d   = 1'b1;
                rd_ptr_d    = next_ptr(rd_ptr_q);
            end
            if (push) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            reject_d   = cmd_valid && !legal;
            overflow_d = cmd_valid && legal && q_full && !pop;

            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            direction_q <= '0;
            dir_idx_q   <= 2'd0;
            changed_q   <= 1'b0;
            reject_q    <= 1'b0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                queue_q[i] <= 2'd0;
            end
        end else begin
            state_q     <= state_d;
            direction_q <= direction_d;
            dir_idx_q   <= dir_idx_d;
            changed_q   <= changed_d;
            reject_q    <= reject_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            if (push) begin
                queue_q[wr_ptr_q] <= code_idx;
            end
        end
    end

    assign direction   = direction_q;
    assign dir_idx     = dir_idx_q;
    assign dir_changed = changed_q;
    assign reject      = reject_q;
    assign overflow    = overflow_q;
    assign q_count     = count_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with DEPTH=2; expected values are hand-derived.
module tb_snake_dir_ctrl;

    localparam logic [31:0] C_UP    = 32'h20DF6A95;
    localparam logic [31:0] C_DOWN  = 32'h20DFEA15;
    localparam logic [31:0] C_LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] C_RIGHT = 32'h20DF9A65;

    logic        game_clk = 1'b0;
    logic        reset_n  = 1'b0;
    logic [31:0] ir_code  = '0;
    logic        ir_valid = 1'b0;
    logic        step     = 1'b0;
    logic        halt     = 1'b0;
    logic [31:0] direction;
    logic [1:0]  dir_idx;
    logic        dir_changed;
    logic        reject;
    logic        overflow;
    logic [1:0]  q_count;

    int total = 0;
    int bad   = 0;

    snake_dir_ctrl #(.DEPTH(2)) dut (
        .game_clk    (game_clk),
        .reset_n     (reset_n),
        .ir_code     (ir_code),
        .ir_valid    (ir_valid),
        .step        (step),
        .halt        (halt),
        .direction   (direction),
        .dir_idx     (dir_idx),
        .dir_changed (dir_changed),
        .reject      (reject),
        .overflow    (overflow),
        .q_count     (q_count)
    );

    always #5 game_clk = ~game_clk;

    task automatic tick();
        @(posedge game_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] c);
        ir_code  = c;
        ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        total++; if (direction !== 32'h0) begin bad++; $display("FAIL reset_dir: got %h want 0", direction); end
        total++; if (dir_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", dir_idx); end
        total++; if (q_count !== 2'd0) begin bad++; $display("FAIL reset_q: got %0d want 0", q_count); end
        total++; if ({dir_changed, reject, overflow} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses: got %b want 000", {dir_changed, reject, overflow});
        end
    endtask

    task automatic test_first_turn();
        send(C_RIGHT);
        total++; if (q_count !== 2'd1) begin bad++; $display("FAIL first_q: got %0d want 1", q_count); end
        total++; if (direction !== 32'h0) begin bad++; $display("FAIL first_idle_dir: got %h want 0", direction); end
        do_step();
        total++; if (direction !== C_RIGHT) begin bad++; $display("FAIL first_dir: got %h want %h", direction, C_RIGHT); end
        total++; if (dir_idx !== 2'd3) begin bad++; $display("FAIL first_idx: got %0d want 3", dir_idx); end
        total++; if (dir_changed !== 1'b1) begin bad++; $display("FAIL first_chg: got %b want 1", dir_changed); end
        total++; if (q_count !== 2'd0) begin bad++; $display("FAIL first_q0: got %0d want 0", q_count); end
        tick();
        total++; if (dir_changed !== 1'b0) begin bad++; $display("FAIL first_chg_end: got %b want 0", dir_changed); end
    endtask

    task automatic test_reject();
        send(C_LEFT);
        total++; if (reject !== 1'b1) begin bad++; $display("FAIL rej_opp: got %b want 1", reject); end
        total++; if (q_count !== 2'd0) begin bad++; $display("FAIL rej_opp_q: got %0d want 0", q_count); end
        tick();
        total++; if (reject !== 1'b0) begin bad++; $display("FAIL rej_pulse_len: got %b want 0", reject); end
        send(C_RIGHT);
        total++; if (reject !== 1'b1) begin bad++; $display("FAIL rej_same: got %b want 1", reject); end
        tick();
    endtask

    task automatic test_overflow();
        send(C_UP);
        send(C_LEFT);
        total++; if (q_count !== 2'd2) begin bad++; $display("FAIL ovf_q2: got %0d want 2", q_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
        send(C_DOWN);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
        total++; if (q_count !== 2'd2) begin bad++; $display("FAIL ovf_q_hold: got %0d want 2", q_count); end
        tick();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pulse_len: got %b want 0", overflow); end
        do_step();
        total++; if (direction !== C_UP) begin bad++; $display("FAIL ovf_pop1: got %h want %h", direction, C_UP); end
        total++; if (q_count !== 2'd1) begin bad++; $display("FAIL ovf_pop1_q: got %0d want 1", q_count); end
        do_step();
        total++; if (direction !== C_LEFT) begin bad++; $display("FAIL ovf_pop2: got %h want %h", direction, C_LEFT); end
        total++; if (dir_idx !== 2'd2) begin bad++; $display("FAIL ovf_pop2_idx: got %0d want 2", dir_idx); end
    endtask

    task automatic test_back_to_back();
        send(C_UP);
        do_step();
        send(C_RIGHT);
        do_step();
        total++; if (direction !== C_RIGHT) begin bad++; $display("FAIL b2b_setup: got %h want %h", direction, C_RIGHT); end
        ir_valid = 1'b1;
        ir_code  = C_UP;
        tick();
        total++; if (q_count !== 2'd1) begin bad++; $display("FAIL b2b_up_q: got %0d want 1", q_count); end
        ir_code = C_DOWN;
        tick();
        total++; if (reject !== 1'b1) begin bad++; $display("FAIL b2b_tail_rej: got %b want 1", reject); end
        ir_code = C_LEFT;
        tick();
        ir_valid = 1'b0;
        total++; if (reject !== 1'b0) begin bad++; $display("FAIL b2b_left_rej: got %b want 0", reject); end
        total++; if (q_count !== 2'd2) begin bad++; $display("FAIL b2b_left_q: got %0d want 2", q_count); end
    endtask

    task automatic test_simul_push_pop();
        ir_code  = C_DOWN;
        ir_valid = 1'b1;
        step     = 1'b1;
        tick();
        ir_valid = 1'b0;
        step     = 1'b0;
        total++; if (direction !== C_UP) begin bad++; $display("FAIL sim_full_dir: got %h want %h", direction, C_UP); end
        total++; if (q_count !== 2'd2) begin bad++; $display("FAIL sim_full_q: got %0d want 2", q_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sim_full_ovf: got %b want 0", overflow); end
        total++; if (dir_changed !== 1'b1) begin bad++; $display("FAIL sim_full_chg: got %b want 1", dir_changed); end
        do_step();
        total++; if (direction !== C_LEFT) begin bad++; $display("FAIL sim_pop_left: got %h want %h", direction, C_LEFT); end
        // One queued entry (DOWN) is the reference even though it pops now.
        ir_code  = C_UP;
        ir_valid = 1'b1;
        step     = 1'b1;
        tick();
        ir_valid = 1'b0;
        step     = 1'b0;
        total++; if (reject !== 1'b1) begin bad++; $display("FAIL sim_one_rej: got %b want 1", reject); end
        total++; if (q_count !== 2'd0) begin bad++; $display("FAIL sim_one_q: got %0d want 0", q_count); end
        total++; if (dir_idx !== 2'd1) begin bad++; $display("FAIL sim_one_idx: got %0d want 1", dir_idx); end
        ir_code  = C_LEFT;
        ir_valid = 1'b1;
        step     = 1'b1;
        tick();
        ir_valid = 1'b0;
        step     = 1'b0;
        total++; if (direction !== C_DOWN) begin bad++; $display("FAIL sim_nobypass_dir: got %h want %h", direction, C_DOWN); end
        total++; if (dir_changed !== 1'b0) begin bad++; $display("FAIL sim_nobypass_chg: got %b want 0", dir_changed); end
        total++; if (q_count !== 2'd1) begin bad++; $display("FAIL sim_nobypass_q: got %0d want 1", q_count); end
        do_step();
        total++; if (direction !== C_LEFT) begin bad++; $display("FAIL sim_next_dir: got %h want %h", direction, C_LEFT); end
    endtask

    task automatic test_ignore_and_empty_step();
        send(32'h12345678);
        total++; if ({reject, overflow} !== 2'b00) begin bad++; $display("FAIL ign_pulses: got %b want 00", {reject, overflow}); end
        total++; if (q_count !== 2'd0) begin bad++; $display("FAIL ign_q: got %0d want 0", q_count); end
        do_step();
        total++; if (direction !== C_LEFT) begin bad++; $display("FAIL empty_step_dir: got %h want %h", direction, C_LEFT); end
        total++; if (dir_changed !== 1'b0) begin bad++; $display("FAIL empty_step_chg: got %b want 0", dir_changed); end
    endtask

    task automatic test_halt();
        send(C_UP);
        send(C_RIGHT);
        total++; if (q_count !== 2'd2) begin bad++; $display("FAIL halt_setup_q: got %0d want 2", q_count); end
        halt     = 1'b1;
        step     = 1'b1;
        ir_code  = C_DOWN;
        ir_valid = 1'b1;
        tick();
        halt     = 1'b0;
        step     = 1'b0;
        ir_valid = 1'b0;
        total++; if (direction !== 32'h0) begin bad++; $display("FAIL halt_dir: got %h want 0", direction); end
        total++; if (q_count !== 2'd0) begin bad++; $display("FAIL halt_q: got %0d want 0", q_count); end
        total++; if (dir_changed !== 1'b1) begin bad++; $display("FAIL halt_chg: got %b want 1", dir_changed); end
        total++; if ({reject, overflow} !== 2'b00) begin bad++; $display("FAIL halt_pulses: got %b want 00", {reject, overflow}); end
        tick();
        total++; if (dir_changed !== 1'b0) begin bad++; $display("FAIL halt_chg_len: got %b want 0", dir_changed); end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        total++; if (dir_changed !== 1'b0) begin bad++; $display("FAIL halt_idle_chg: got %b want 0", dir_changed); end
        send(C_DOWN);
        total++; if (q_count !== 2'd1) begin bad++; $display("FAIL idle_any_q: got %0d want 1", q_count); end
        do_step();
        total++; if (dir_idx !== 2'd1) begin bad++; $display("FAIL idle_run_idx: got %0d want 1", dir_idx); end
        send(C_LEFT);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        total++; if (q_count !== 2'd0) begin bad++; $display("FAIL midreset_q: got %0d want 0", q_count); end
        total++; if (direction !== 32'h0) begin bad++; $display("FAIL midreset_dir: got %h want 0", direction); end
    endtask

    initial begin
        test_reset();
        test_first_turn();
        test_reject();
        test_overflow();
        test_back_to_back();
        test_simul_push_pop();
        test_ignore_and_empty_step();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
